// File: rtl/mssd_frame_arbiter.sv
// Round-robin transmit scheduler for four requesters feeding one MSSD serial line.
// Frames are start bit, 2-bit port address, 4-bit length, then len payload bits MSB first.
module mssd_frame_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        clkEN,
    input  logic [3:0]  req,
    input  logic [3:0]  len0,
    input  logic [3:0]  len1,
    input  logic [3:0]  len2,
    input  logic [3:0]  len3,
    input  logic [14:0] data0,
    input  logic [14:0] data1,
    input  logic [14:0] data2,
    input  logic [14:0] data3,
    output logic [3:0]  gnt,
    output logic        SerOut,
    output logic        SerOutValid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {StIdle, StStart, StAddr, StLen, StData} state_e;

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [14:0] data_q, data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ser_q, ser_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  gnt_q, gnt_d;

    logic        found;
    logic [1:0]  win;
    logic [3:0]  win_len;
    logic [14:0] win_data;
    logic [3:0]  cnt_m1;
    logic [3:0]  len_m1;

    // Search upward from ptr, wrapping modulo 4; first asserted request wins.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[ptr_q + 2'(i)]) begin
                found = 1'b1;
                win   = ptr_q + 2'(i);
            end
        end
    end

    always_comb begin
        win_len  = len0;
        win_data = data0;
        case (win)
            2'd0: begin win_len = len0; win_data = data0; end
            2'd1: begin win_len = len1; win_data = data1; end
            2'd2: begin win_len = len2; win_data = data2; end
            default: begin win_len = len3; win_data = data3; end
        endcase
    end

    assign cnt_m1 = cnt_q - 4'd1;
    assign len_m1 = len_q - 4'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        len_d   = len_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gnt_d   = 4'b0000;
        if (clkEN) begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        gnt_d   = 4'b0001 << win;
                        addr_d  = win;
                        len_d   = win_len;
                        data_d  = win_data;
                        ptr_d   = win + 2'd1;
                        ser_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = StStart;
                    end
                end
                StStart: begin
                    ser_d   = addr_q[1];
                    cnt_d   = 4'd1;
                    state_d = StAddr;
                end
                StAddr: begin
                    ser_d   = addr_q[0];
                    cnt_d   = 4'd4;
                    state_d = StLen;
                end
                StLen: begin
                    // cnt counts remaining length bits; at 0 the field is fully on the line.
                    if (cnt_q != 4'd0) begin
                        ser_d = len_q[cnt_m1[1:0]];
                        cnt_d = cnt_m1;
                    end else if (len_q != 4'd0) begin
                        ser_d   = data_q[len_m1];
                        cnt_d   = len_m1;
                        valid_d = 1'b1;
                        state_d = StData;
                    end else begin
                        ser_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
                StData: begin
                    if (cnt_q != 4'd0) begin
                        ser_d = data_q[cnt_m1];
                        cnt_d = cnt_m1;
                    end else begin
                        ser_d   = 1'b1;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            addr_q  <= 2'd0;
            len_q   <= 4'd0;
            data_q  <= 15'd0;
            cnt_q   <= 4'd0;
            ser_q   <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign SerOut      = ser_q;
    assign SerOutValid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
